fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Requester-side counterpart of the program-counter block.
- Reads the current PC address and fetches the instruction at that address from synchronous instruction memory.
- Buffers fetched instructions in a small FIFO for the decode stage.
- Advances the PC with the two-phase push/addcontrol step protocol, applying a sequential (+1) or branch (+offset+1) increment.
- Sits between the PC block, instruction memory and decode.

Parameters:
- ADDR_W, 32, width of PC/instruction address.
- DATA_W, 32, instruction width.
- FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- pc_addr  in  ADDR_W  current PC address from the PC block.
- pc_next  in  1  PC ready/next indicator; monitored only, exposed via debug.
- pc_push  out  1  step request to the PC.
- pc_addcontrol  out  1  step arm to the PC.
- pc_inc  out  ADDR_W  increment offset to the PC; PC computes addr+inc+1.
- branch_valid  in  1  one-cycle pulse: redirect pending.
- branch_offset  in  ADDR_W  signed word offset, sampled with branch_valid.
- flush  in  1  discard buffered and in-flight instructions.
- imem_req  out  1  memory read strobe.
- imem_addr  out  ADDR_W  memory read address.
- imem_data  in  DATA_W  read data, valid exactly one cycle after imem_req.
- inst_valid  out  1  FIFO head valid.
- inst_data  out  DATA_W  FIFO head instruction.
- inst_pc  out  ADDR_W  address of the head instruction.
- inst_ready  in  1  decode accepts the head when inst_valid && inst_ready.
- dbg_pc_next  out  1  registered copy of pc_next.

Behaviour:
- Reset (reset==0 at a rising edge):
  - pc_push=0, pc_addcontrol=0, pc_inc=0, imem_req=0, imem_addr=0.
  - FIFO emptied, so inst_valid=0; inst_data and inst_pc read as 0.
  - Branch-pending register cleared, drop flag cleared, dbg_pc_next=0.
  - State=FETCH.
  - Reset in any state aborts that state. A read in flight is ignored, and any half-completed step leaves the outputs at 0, which re-arms the PC.
- FSM states: FETCH, WAIT, ARM, REL.
  - FETCH: if FIFO count < FIFO_DEPTH, assert imem_req=1 and imem_addr=pc_addr, latch pc_addr into tag_pc, then go to WAIT. Otherwise hold in FETCH with imem_req=0.
  - WAIT: imem_req=0. Write {imem_data, tag_pc} into the FIFO unless the drop flag is set. Clear the drop flag, then go to ARM. The FIFO cannot be full here because space was reserved in FETCH and decode only removes entries.
  - ARM: pc_push=1 and pc_addcontrol=1 for exactly one cycle. pc_inc = pending offset if a branch is pending, else 0. Clear pending, then go to REL.
  - REL: pc_push=0, pc_addcontrol=0, pc_inc=0 for exactly one cycle, then go to FETCH. This cycle is mandatory: the PC only re-arms after it sees addcontrol low.
- Throughput: one instruction per 4 cycles when not stalled. First imem_req is the cycle after reset deasserts.
- Branch handling:
  - branch_valid latches branch_offset into the pending register in any state; a later pulse overwrites an earlier unconsumed one.
  - branch_valid in the ARM cycle itself: that cycle's branch_offset drives pc_inc directly and nothing stays pending.
  - pc_inc is ADDR_W wide and two's-complement. Wrap-around of addr+inc+1 is the PC's concern; the sequencer does no range checks.
- Flush:
  - Empties the FIFO the next cycle.
  - If the state is WAIT, or flush coincides with FETCH issuing a read, sets the drop flag so that fetched instruction is discarded.
  - Does not cancel an ARM/REL already entered.
  - Flush coincident with a FIFO write or read: flush wins, FIFO ends empty.
- FIFO:
  - First-word fall-through. inst_valid = count!=0.
  - Simultaneous push and pop when full or empty is legal; count unchanged when full.
  - Pointers wrap modulo FIFO_DEPTH.
- dbg_pc_next registers pc_next every cycle.

Decomposition:
- Shared package:
  - State encoding constants FETCH=2'd0, WAIT=2'd1, ARM=2'd2, REL=2'd3.
  - ADDR_W/DATA_W defaults.
  - Instruction+tag entry width constant.
- One sub-module: inst_fifo, a parameterised FWFT FIFO of {DATA_W+ADDR_W} entries with push, pop, flush and count.

Test Plan:
- Reset then sequential run: PC model starts at 0, imem[n]=32'hA000_0000+n, inst_ready=1 → imem_req at addresses 0,1,2,3 every 4 cycles. pc_inc=0 at each ARM, and ARM is always followed by one REL cycle with both strobes low. Output stream is (inst_pc,inst_data)=(0,A0000000),(1,A0000001)…
- Backpressure: inst_ready=0 → after 2 entries, FETCH holds with imem_req=0 and the PC stays at 2. Raising inst_ready resumes fetch at address 2 with no loss or duplication.
- Branch: branch_valid with offset 5 while in WAIT for address 3 → next ARM has pc_inc=5, and the next fetch address is 9.
- Branch coincident with ARM: offset 32'hFFFF_FFFC (-4) at address 8 → pc_inc=-4 in that same cycle, next fetch address 5, pending register empty afterwards.
- Flush in WAIT: FIFO holds 1 entry, flush asserted → FIFO empty next cycle. The in-flight instruction is dropped and inst_valid stays 0 until the following fetch completes.
- Reset mid-ARM: reset=0 during ARM → next cycle pc_push=0, pc_addcontrol=0, FIFO empty, state FETCH. The first request after release uses the current pc_addr.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
//   Shared definitions for the fetch sequencer slice: default bus widths,
//   the width of one buffered {instruction, pc} entry, and the FSM state
//   encoding used by the sequencer top.
package fetch_sequencer_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned ENTRY_W_DEF = DATA_W_DEF + ADDR_W_DEF;

  // Fetch/step cycle: FETCH issues the read, WAIT captures it,
  // ARM and REL perform the two-phase PC step.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ARM   = 2'd2,
    REL   = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
//   Bundles every non-clock/reset signal of the fetch sequencer.
//   master : sequencer view (drives PC step, memory read, decode head, debug)
//   slave  : environment view (PC block, instruction memory, decode)
//   Signals: pc_addr/pc_next/pc_push/pc_addcontrol/pc_inc  - PC block
//            branch_valid/branch_offset/flush              - redirect control
//            imem_req/imem_addr/imem_data                  - instruction memory
//            inst_valid/inst_data/inst_pc/inst_ready       - decode stage
//            dbg_pc_next                                   - debug copy
interface fetch_sequencer_if import fetch_sequencer_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic [ADDR_W-1:0] pc_addr;
  logic              pc_next;
  logic              pc_push;
  logic              pc_addcontrol;
  logic [ADDR_W-1:0] pc_inc;
  logic              branch_valid;
  logic [ADDR_W-1:0] branch_offset;
  logic              flush;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              inst_valid;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;
  logic              dbg_pc_next;

  modport master (
    input  pc_addr, pc_next, branch_valid, branch_offset, flush,
           imem_data, inst_ready,
    output pc_push, pc_addcontrol, pc_inc, imem_req, imem_addr,
           inst_valid, inst_data, inst_pc, dbg_pc_next
  );

  modport slave (
    output pc_addr, pc_next, branch_valid, branch_offset, flush,
           imem_data, inst_ready,
    input  pc_push, pc_addcontrol, pc_inc, imem_req, imem_addr,
           inst_valid, inst_data, inst_pc, dbg_pc_next
  );

endinterface

// File: rtl/fetch_sequencer_inst_fifo.sv
// inst_fifo
//   First-word fall-through FIFO holding {instruction, pc} entries.
//   Ports: clk, reset (sync, active-low), push_i/wdata_i write side,
//          pop_i read side (ignored when empty), flush_i (empties next cycle,
//          wins over a coincident push or pop), valid_i/rdata_o head,
//          count_o occupancy. rdata_o reads 0 while empty.
module inst_fifo import fetch_sequencer_pkg::*; #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = ENTRY_W_DEF,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push_s, do_pop_s;

  // Qualify push/pop and compute pointer/count next state.
  always_comb begin
    do_pop_s  = 1'b0;
    do_push_s = 1'b0;
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    if (pop_i && (cnt_q != '0)) begin
      do_pop_s = 1'b1;
    end else begin
      do_pop_s = 1'b0;
    end
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    if (push_i && ((cnt_q != FULL_C) || do_pop_s)) begin
      do_push_s = 1'b1;
    end else begin
      do_push_s = 1'b0;
    end
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push_s) begin
        wr_d = wr_q + PTR_W'(1);
      end else begin
        wr_d = wr_q;
      end
      if (do_pop_s) begin
        rd_d = rd_q + PTR_W'(1);
      end else begin
        rd_d = rd_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are only visible through the valid-gated head.
  always_ff @(posedge clk) begin
    if (reset && do_push_s && !flush_i) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  // Head presentation, forced to zero while empty.
  always_comb begin
    valid_o = (cnt_q != '0);
    count_o = cnt_q;
    if (valid_o) begin
      rdata_o = mem_q[rd_q];
    end else begin
      rdata_o = '0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Requester-side partner of the PC block. Reads the PC, fetches the
//   instruction from synchronous memory, buffers it for decode, then steps
//   the PC with the push/addcontrol two-phase protocol (one instruction per
//   four cycles when not stalled).
//   Ports: clk, reset (sync, active-low), bus (fetch_sequencer_if.master)
//   carrying the PC, memory, decode, redirect and debug signals.
module fetch_sequencer import fetch_sequencer_pkg::*; #(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic                clk,
  input logic                reset,
  fetch_sequencer_if.master  bus
);

  localparam int unsigned ENTRY_W = DATA_W + ADDR_W;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] tag_pc_q, tag_pc_d;
  logic              drop_q, drop_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_off_q, pend_off_d;
  logic              dbg_q;

  logic              imem_req_s;
  logic [ADDR_W-1:0] imem_addr_s;
  logic              pc_push_s, pc_add_s;
  logic [ADDR_W-1:0] pc_inc_s;
  logic              fifo_push_s, fifo_flush_s;
  logic              fifo_valid_s;
  logic [ENTRY_W-1:0] fifo_rdata_s;
  logic [CNT_W-1:0]  fifo_cnt_s;

  inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push_s),
    .wdata_i ({bus.imem_data, tag_pc_q}),
    .pop_i   (bus.inst_ready),
    .flush_i (fifo_flush_s),
    .valid_o (fifo_valid_s),
    .rdata_o (fifo_rdata_s),
    .count_o (fifo_cnt_s)
  );

  // FSM next state, branch bookkeeping and strobe generation.
  always_comb begin
    state_d      = state_q;
    tag_pc_d     = tag_pc_q;
    drop_d       = drop_q;
    pend_valid_d = pend_valid_q;
    pend_off_d   = pend_off_q;
    imem_req_s   = 1'b0;
    imem_addr_s  = '0;
    pc_push_s    = 1'b0;
    pc_add_s     = 1'b0;
    pc_inc_s     = '0;
    fifo_push_s  = 1'b0;
    fifo_flush_s = 1'b0;
    if (!reset) begin
      // Outputs stay low while reset is held so a half-done step re-arms the PC.
      state_d      = FETCH;
      tag_pc_d     = '0;
      drop_d       = 1'b0;
      pend_valid_d = 1'b0;
      pend_off_d   = '0;
    end else begin
      fifo_flush_s = bus.flush;
      // A later redirect overwrites an earlier one not yet consumed.
      if (bus.branch_valid) begin
        pend_valid_d = 1'b1;
        pend_off_d   = bus.branch_offset;
      end else begin
        pend_valid_d = pend_valid_q;
        pend_off_d   = pend_off_q;
      end
      case (state_q)
        FETCH: begin
          // Issue only with a free slot; that slot is then reserved for WAIT.
          if (fifo_cnt_s < DEPTH_C) begin
            imem_req_s  = 1'b1;
            imem_addr_s = bus.pc_addr;
            tag_pc_d    = bus.pc_addr;
            drop_d      = bus.flush;
            state_d     = WAIT;
          end else begin
            state_d = FETCH;
          end
        end
        WAIT: begin
          // A flush in this cycle also discards the returning word because
          // the FIFO flush overrides the push.
          fifo_push_s = !drop_q;
          drop_d      = 1'b0;
          state_d     = ARM;
        end
        ARM: begin
          pc_push_s = 1'b1;
          pc_add_s  = 1'b1;
          // Same-cycle redirect bypasses the pending register entirely.
          if (bus.branch_valid) begin
            pc_inc_s = bus.branch_offset;
          end else if (pend_valid_q) begin
            pc_inc_s = pend_off_q;
          end else begin
            pc_inc_s = '0;
          end
          pend_valid_d = 1'b0;
          pend_off_d   = '0;
          state_d      = REL;
        end
        REL: begin
          // Strobes low for one cycle so the PC can re-arm.
          state_d = FETCH;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= FETCH;
      tag_pc_q     <= '0;
      drop_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_off_q   <= '0;
    end else begin
      state_q      <= state_d;
      tag_pc_q     <= tag_pc_d;
      drop_q       <= drop_d;
      pend_valid_q <= pend_valid_d;
      pend_off_q   <= pend_off_d;
    end
  end

  // Debug copy of the PC ready indicator.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dbg_q <= 1'b0;
    end else begin
      dbg_q <= bus.pc_next;
    end
  end

  assign bus.imem_req      = imem_req_s;
  assign bus.imem_addr     = imem_addr_s;
  assign bus.pc_push       = pc_push_s;
  assign bus.pc_addcontrol = pc_add_s;
  assign bus.pc_inc        = pc_inc_s;
  assign bus.inst_valid    = fifo_valid_s;
  assign bus.inst_data     = fifo_rdata_s[ENTRY_W-1:ADDR_W];
  assign bus.inst_pc       = fifo_rdata_s[ADDR_W-1:0];
  assign bus.dbg_pc_next   = dbg_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Cycle-by-cycle directed vectors against fetch_sequencer with a small PC
//   model (two-phase step, re-arm on addcontrol low) and a synchronous
//   instruction memory returning 32'hA000_0000 + address.
module tb_fetch_sequencer;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        bv;
    logic [31:0] boff;
    logic        fl;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_arm;
    logic [31:0] e_inc;
    logic        e_val;
    logic [31:0] e_ipc;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_miss = 0;
  vec_t vecs[$];

  logic [31:0] pc_q    = 32'h0;
  logic        armed_q = 1'b1;
  logic [31:0] imem_q  = 32'h0;
  logic        dbg_exp = 1'b0;

  fetch_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  fetch_sequencer #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.pc_addr   = pc_q;
  assign bus.pc_next   = armed_q;
  assign bus.imem_data = imem_q;

  // PC block, instruction memory and expected debug copy.
  always @(posedge clk) begin
    if (armed_q && bus.pc_push && bus.pc_addcontrol) begin
      pc_q    <= pc_q + bus.pc_inc + 32'd1;
      armed_q <= 1'b0;
    end else if (!bus.pc_addcontrol) begin
      armed_q <= 1'b1;
    end
    if (bus.imem_req) imem_q <= 32'hA000_0000 + bus.imem_addr;
    dbg_exp <= reset ? armed_q : 1'b0;
  end

  function automatic vec_t mk(input logic rst, input logic rdy, input logic bv,
                              input logic [31:0] boff, input logic fl,
                              input logic req, input logic [31:0] addr,
                              input logic arm, input logic [31:0] inc,
                              input logic val, input logic [31:0] ipc);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.bv = bv; v.boff = boff; v.fl = fl;
    v.e_req = req; v.e_addr = addr; v.e_arm = arm; v.e_inc = inc;
    v.e_val = val; v.e_ipc = ipc;
    return v;
  endfunction

  task automatic add(input logic rst, input logic rdy, input logic bv,
                     input logic [31:0] boff, input logic fl,
                     input logic req, input logic [31:0] addr,
                     input logic arm, input logic [31:0] inc,
                     input logic val, input logic [31:0] ipc);
    vecs.push_back(mk(rst, rdy, bv, boff, fl, req, addr, arm, inc, val, ipc));
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s vec %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [31:0] exp_data;
    reset              = v.rst;
    bus.inst_ready     = v.rdy;
    bus.branch_valid   = v.bv;
    bus.branch_offset  = v.boff;
    bus.flush          = v.fl;
    @(negedge clk);
    n_vec++;
    exp_data = v.e_val ? (32'hA000_0000 + v.e_ipc) : 32'h0;
    chk("imem_req", idx, {31'd0, bus.imem_req}, {31'd0, v.e_req});
    if (v.e_req) chk("imem_addr", idx, bus.imem_addr, v.e_addr);
    chk("pc_push", idx, {31'd0, bus.pc_push}, {31'd0, v.e_arm});
    chk("pc_addcontrol", idx, {31'd0, bus.pc_addcontrol}, {31'd0, v.e_arm});
    chk("pc_inc", idx, bus.pc_inc, v.e_inc);
    chk("inst_valid", idx, {31'd0, bus.inst_valid}, {31'd0, v.e_val});
    chk("inst_pc", idx, bus.inst_pc, v.e_val ? v.e_ipc : 32'h0);
    chk("inst_data", idx, bus.inst_data, exp_data);
    chk("dbg_pc_next", idx, {31'd0, bus.dbg_pc_next}, {31'd0, dbg_exp});
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] Z = 32'h0;
  localparam logic [31:0] M4 = 32'hFFFF_FFFC;

  initial begin
    reset = 1'b0; bus.inst_ready = 1'b1; bus.branch_valid = 1'b0;
    bus.branch_offset = 32'h0; bus.flush = 1'b0;
    //   rst rdy bv boff fl | req addr arm inc val ipc
    // reset, then sequential run 0,1 with decode always ready
    add(0,1,0,Z,0, 0,Z,    0,Z,0,Z);     // 0  reset held: all strobes low
    add(1,1,0,Z,0, 1,32'd0,0,Z,0,Z);     // 1  first request right after release
    add(1,1,0,Z,0, 0,Z,    0,Z,0,Z);     // 2  WAIT
    add(1,1,0,Z,0, 0,Z,    1,Z,1,32'd0); // 3  ARM, head (0,A0000000)
    add(1,1,0,Z,0, 0,Z,    0,Z,0,Z);     // 4  REL
    add(1,1,0,Z,0, 1,32'd1,0,Z,0,Z);     // 5
    add(1,1,0,Z,0, 0,Z,    0,Z,0,Z);     // 6
    add(1,1,0,Z,0, 0,Z,    1,Z,1,32'd1); // 7
    add(1,1,0,Z,0, 0,Z,    0,Z,0,Z);     // 8
    // backpressure: two entries fill, FETCH holds, then resumes
    add(1,0,0,Z,0, 1,32'd2,0,Z,0,Z);     // 9
    add(1,0,0,Z,0, 0,Z,    0,Z,0,Z);     // 10
    add(1,0,0,Z,0, 0,Z,    1,Z,1,32'd2); // 11
    add(1,0,0,Z,0, 0,Z,    0,Z,1,32'd2); // 12
    add(1,0,0,Z,0, 1,32'd3,0,Z,1,32'd2); // 13
    add(1,0,0,Z,0, 0,Z,    0,Z,1,32'd2); // 14
    add(1,0,0,Z,0, 0,Z,    1,Z,1,32'd2); // 15
    add(1,0,0,Z,0, 0,Z,    0,Z,1,32'd2); // 16
    add(1,0,0,Z,0, 0,Z,    0,Z,1,32'd2); // 17 full: no request
    add(1,1,0,Z,0, 0,Z,    0,Z,1,32'd2); // 18 still full this cycle
    add(1,1,0,Z,0, 1,32'd4,0,Z,1,32'd3); // 19 resumes at 4, head 3
    add(1,1,0,Z,0, 0,Z,    0,Z,0,Z);     // 20
    add(1,1,0,Z,0, 0,Z,    1,Z,1,32'd4); // 21
    add(1,1,0,Z,0, 0,Z,    0,Z,0,Z);     // 22
    // branch pulse during WAIT, offset 5 at address 5 -> next fetch 11
    add(1,1,0,Z,0,      1,32'd5, 0,Z,    0,Z);      // 23
    add(1,1,1,32'd5,0,  0,Z,     0,Z,    0,Z);      // 24
    add(1,1,0,Z,0,      0,Z,     1,32'd5,1,32'd5);  // 25
    add(1,1,0,Z,0,      0,Z,     0,Z,    0,Z);      // 26
    // branch in the ARM cycle itself, -4 at address 11 -> next fetch 8
    add(1,1,0,Z,0,      1,32'd11,0,Z,    0,Z);      // 27
    add(1,1,0,Z,0,      0,Z,     0,Z,    0,Z);      // 28
    add(1,1,1,M4,0,     0,Z,     1,M4,   1,32'd11); // 29
    add(1,1,0,Z,0,      0,Z,     0,Z,    0,Z);      // 30
    add(1,1,0,Z,0,      1,32'd8, 0,Z,    0,Z);      // 31
    add(1,1,0,Z,0,      0,Z,     0,Z,    0,Z);      // 32
    add(1,1,0,Z,0,      0,Z,     1,Z,    1,32'd8);  // 33 nothing left pending
    add(1,1,0,Z,0,      0,Z,     0,Z,    0,Z);      // 34
    // flush in WAIT with one entry buffered
    add(1,0,0,Z,0, 1,32'd9, 0,Z,0,Z);      // 35
    add(1,0,0,Z,0, 0,Z,     0,Z,0,Z);      // 36
    add(1,0,0,Z,0, 0,Z,     1,Z,1,32'd9);  // 37
    add(1,0,0,Z,0, 0,Z,     0,Z,1,32'd9);  // 38
    add(1,0,0,Z,0, 1,32'd10,0,Z,1,32'd9);  // 39
    add(1,0,0,Z,1, 0,Z,     0,Z,1,32'd9);  // 40 flush in WAIT
    add(1,0,0,Z,0, 0,Z,     1,Z,0,Z);      // 41 emptied, word 10 dropped
    add(1,0,0,Z,0, 0,Z,     0,Z,0,Z);      // 42
    add(1,0,0,Z,0, 1,32'd11,0,Z,0,Z);      // 43
    add(1,0,0,Z,0, 0,Z,     0,Z,0,Z);      // 44
    add(1,1,0,Z,0, 0,Z,     1,Z,1,32'd11); // 45 next fetch lands normally
    add(1,1,0,Z,0, 0,Z,     0,Z,0,Z);      // 46
    // flush coincident with FETCH issuing a read
    add(1,1,0,Z,1, 1,32'd12,0,Z,0,Z);      // 47
    add(1,1,0,Z,0, 0,Z,     0,Z,0,Z);      // 48
    add(1,1,0,Z,0, 0,Z,     1,Z,0,Z);      // 49 word 12 discarded
    add(1,1,0,Z,0, 0,Z,     0,Z,0,Z);      // 50
    add(1,1,0,Z,0, 1,32'd13,0,Z,0,Z);      // 51
    add(1,1,0,Z,0, 0,Z,     0,Z,0,Z);      // 52
    add(1,1,0,Z,0, 0,Z,     1,Z,1,32'd13); // 53
    add(1,1,0,Z,0, 0,Z,     0,Z,0,Z);      // 54
    // reset during ARM: no step, restart from the unchanged PC
    add(1,1,0,Z,0, 1,32'd14,0,Z,0,Z);      // 55
    add(1,1,0,Z,0, 0,Z,     0,Z,0,Z);      // 56
    add(0,1,0,Z,0, 0,Z,     0,Z,1,32'd14); // 57 strobes forced low
    add(1,1,0,Z,0, 1,32'd14,0,Z,0,Z);      // 58 FIFO empty, refetch 14
    add(1,1,0,Z,0, 0,Z,     0,Z,0,Z);      // 59
    add(1,1,0,Z,0, 0,Z,     1,Z,1,32'd14); // 60
    add(1,1,0,Z,0, 0,Z,     0,Z,0,Z);      // 61
    // two pulses before ARM: the later offset wins (15+2+1=18)
    add(1,1,1,32'd7,0, 1,32'd15,0,Z,    0,Z);      // 62
    add(1,1,1,32'd2,0, 0,Z,     0,Z,    0,Z);      // 63
    add(1,1,0,Z,0,     0,Z,     1,32'd2,1,32'd15); // 64
    add(1,1,0,Z,0,     0,Z,     0,Z,    0,Z);      // 65
    add(1,1,0,Z,0,     1,32'd18,0,Z,    0,Z);      // 66

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Hand sequence: reset held three cycles over an in-flight read; the
    // returned word is ignored and the restart refetches address 18.
    apply(mk(0,1,0,Z,0, 0,Z,     0,Z,0,Z),      100);
    apply(mk(0,1,0,Z,0, 0,Z,     0,Z,0,Z),      101);
    apply(mk(0,1,0,Z,0, 0,Z,     0,Z,0,Z),      102);
    apply(mk(1,1,0,Z,0, 1,32'd18,0,Z,0,Z),      103);
    apply(mk(1,1,0,Z,0, 0,Z,     0,Z,0,Z),      104);
    apply(mk(1,1,0,Z,0, 0,Z,     1,Z,1,32'd18), 105);
    apply(mk(1,1,0,Z,0, 0,Z,     0,Z,0,Z),      106);
    apply(mk(1,1,0,Z,0, 1,32'd19,0,Z,0,Z),      107);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
